// File: rtl/mix_columns_engine_pkg.sv
// Shared types and GF(2^8) helpers for the iterative MixColumns engine.
//   state_t   : 128-bit AES state, byte k at [127-8k -: 8]
//   column_t  : one column, row 0 in the most significant byte ([3])
//   mc_mode_t : forward / inverse / bypass
//   fsm_t     : engine control states
package mix_columns_engine_pkg;

  typedef logic [127:0]    state_t;
  typedef logic [3:0][7:0] column_t;

  typedef enum logic [1:0] {
    MC_FWD    = 2'b00,
    MC_INV    = 2'b01,
    MC_BYPASS = 2'b10
  } mc_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } fsm_t;

  // Multiplication by constants in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] a);
    return gf_mul2(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    return gf_mul2(gf_mul2(gf_mul2(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    return gf_mul2(gf_mul2(gf_mul2(a))) ^ gf_mul2(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    return gf_mul2(gf_mul2(gf_mul2(a))) ^ gf_mul2(gf_mul2(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    return gf_mul2(gf_mul2(gf_mul2(a))) ^ gf_mul2(gf_mul2(a)) ^ gf_mul2(a);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns on a single column.
//   col    : input column (row 0 in col[3])
//   mode   : MC_FWD / MC_INV; anything else passes the column through
//   result : transformed column, same layout
module mix_column_word
  import mix_columns_engine_pkg::*;
(
  input  column_t  col,
  input  mc_mode_t mode,
  output column_t  result
);

  logic [7:0] b0, b1, b2, b3;

  assign b0 = col[3];
  assign b1 = col[2];
  assign b2 = col[1];
  assign b3 = col[0];

  always_comb begin
    result = col;
    case (mode)
      MC_FWD: begin
        result[3] = gf_mul2(b0) ^ gf_mul3(b1) ^ b2 ^ b3;
        result[2] = b0 ^ gf_mul2(b1) ^ gf_mul3(b2) ^ b3;
        result[1] = b0 ^ b1 ^ gf_mul2(b2) ^ gf_mul3(b3);
        result[0] = gf_mul3(b0) ^ b1 ^ b2 ^ gf_mul2(b3);
      end
      MC_INV: begin
        result[3] = gf_mul14(b0) ^ gf_mul11(b1) ^ gf_mul13(b2) ^ gf_mul9(b3);
        result[2] = gf_mul9(b0) ^ gf_mul14(b1) ^ gf_mul11(b2) ^ gf_mul13(b3);
        result[1] = gf_mul13(b0) ^ gf_mul9(b1) ^ gf_mul14(b2) ^ gf_mul11(b3);
        result[0] = gf_mul11(b0) ^ gf_mul13(b1) ^ gf_mul9(b2) ^ gf_mul14(b3);
      end
      default: result = col;
    endcase
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns engine: accepts a state over valid/ready, transforms
// COLS_PER_CYCLE columns per clock in a working register, and holds the
// result on out_valid until out_ready.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake (in_ready is registered)
//   in_state, in_mode     : state and mode, sampled only at accept
//   out_valid/out_ready   : output handshake, result held while stalled
//   out_state             : transformed state
//   busy                  : high from accept until handoff
module mix_columns_engine
  import mix_columns_engine_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4,
  parameter bit OUT_REG        = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     in_state,
  input  logic [1:0] in_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     out_state,
  output logic       busy
);

  localparam int         CPC      = COLS_PER_CYCLE;
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  if (!(CPC == 1 || CPC == 2 || CPC == 4)) begin : g_bad_cpc
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_t             fsm;
  mc_mode_t         mode_q;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  // Column c lives at wrk[~c] so that column 0 occupies the top 32 bits.
  logic [3:0][31:0] wrk;
  state_t           out_q;

  logic [1:0]       idx     [CPC];
  column_t          col_in  [CPC];
  column_t          col_out [CPC];

  // Wraps to 0 after the last group; with CPC=4 the step itself is 0.
  assign cnt_nxt = cnt + CNT_STEP;

  for (genvar g = 0; g < CPC; g++) begin : g_lane
    assign idx[g]    = cnt + 2'(g);
    assign col_in[g] = wrk[~idx[g]];

    mix_column_word u_word (
      .col    (col_in[g]),
      .mode   (mode_q),
      .result (col_out[g])
    );
  end

  assign out_state = OUT_REG ? out_q : state_t'(wrk);

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm       <= ST_IDLE;
      mode_q    <= MC_FWD;
      cnt       <= '0;
      wrk       <= '0;
      out_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            wrk      <= in_state;
            // Reserved 11 folds into bypass.
            mode_q   <= in_mode[1] ? MC_BYPASS : mc_mode_t'(in_mode);
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (mode_q == MC_BYPASS) begin
            fsm       <= ST_DONE;
            out_valid <= !OUT_REG;
          end else begin
            fsm <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int g = 0; g < CPC; g++) wrk[~idx[g]] <= col_out[g];
          cnt <= cnt_nxt;
          if (cnt_nxt == 2'd0) begin
            fsm       <= ST_DONE;
            out_valid <= !OUT_REG;
          end
        end
        ST_DONE: begin
          // With an output register, the first DONE cycle copies the result.
          if (OUT_REG && !out_valid) begin
            out_q     <= wrk;
            out_valid <= 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= ST_IDLE;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three configurations share one input stream
// and are compared against a matrix-multiply reference model.
module tb_mix_columns_engine;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_state = '0;
  logic [1:0]   in_mode = 2'b00;
  logic [2:0]   in_ready, out_valid, busy;
  logic [127:0] out_state [3];

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] res [3];
  int           lat [3];
  int           lat_fwd [3] = '{3, 6, 3};
  int           lat_byp [3] = '{2, 2, 1};

  always #5 clock = ~clock;

  mix_columns_engine #(.COLS_PER_CYCLE(4), .OUT_REG(1'b1)) u_c4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_state(out_state[0]), .busy(busy[0]));

  mix_columns_engine #(.COLS_PER_CYCLE(1), .OUT_REG(1'b1)) u_c1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_state(out_state[1]), .busy(busy[1]));

  mix_columns_engine #(.COLS_PER_CYCLE(2), .OUT_REG(1'b0)) u_c2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_state(out_state[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Shift-and-add GF(2^8) product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Circulant matrix times each column; mode bit 1 set means pass-through.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [1:0] md);
    logic [127:0] o = '0;
    logic [7:0]   acc;
    int           base [4];
    if (md[1]) return s;
    if (md[0]) base = '{14, 11, 13, 9};
    else       base = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(8'(base[(k - r + 4) % 4]), s[127 - 8*(4*c + k) -: 8]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    return o;
  endfunction

  // One transaction on all three engines with out_ready held high.
  task automatic run(input logic [127:0] st, input logic [1:0] md);
    logic [2:0] seen = 3'b000;
    @(negedge clock);
    in_state = st; in_mode = md; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", {125'd0, busy}, 128'd7);
    chk("in_ready_after_accept", {125'd0, in_ready}, 128'd0);
    for (int i = 0; i < 3; i++) begin lat[i] = -1; res[i] = 'x; end
    for (int cyc = 1; cyc <= 20 && seen != 3'b111; cyc++) begin
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++)
        if (!seen[i] && out_valid[i]) begin
          seen[i] = 1'b1; lat[i] = cyc; res[i] = out_state[i];
        end
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_txn(input string tag, input logic [127:0] exp, input logic byp);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_state_u%0d", tag, i), res[i], exp);
      chk($sformatf("%s_latency_u%0d", tag, i), 128'(lat[i]), 128'(byp ? lat_byp[i] : lat_fwd[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v1, e1, v2, e2, vb, s, f, a, b;
    logic [127:0] snap [3];
    logic [2:0]   stable;
    logic [2:0]   seen;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_in_ready", {125'd0, in_ready}, 128'd7);
    chk("reset_out_valid", {125'd0, out_valid}, 128'd0);
    chk("reset_busy", {125'd0, busy}, 128'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_out_state_u%0d", i), out_state[i], '0);
    @(negedge clock);
    reset = 1'b0;

    v1 = {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101};
    e1 = {32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101};
    v2 = {32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6, 32'hf20a225c};
    e2 = {32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6, 32'h9fdc589d};
    vb = 128'h000102030405060708090a0b0c0d0e0f;

    run(v1, 2'b00); check_txn("fwd_vec1", e1, 1'b0);
    run(v2, 2'b00); check_txn("fwd_vec2", e2, 1'b0);
    run(e1, 2'b01); check_txn("inv_vec1", v1, 1'b0);
    run(e2, 2'b01); check_txn("inv_vec2", v2, 1'b0);
    run(vb, 2'b10); check_txn("bypass", vb, 1'b1);
    run(vb, 2'b11); check_txn("reserved", vb, 1'b1);

    for (int n = 0; n < 100; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run(s, 2'b00); check_txn("rand_fwd", ref_mix(s, 2'b00), 1'b0);
      f = res[0];
      run(f, 2'b01); check_txn("rand_roundtrip", s, 1'b0);
    end

    // Backpressure: hold out_ready low while a second state waits upstream.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = ~a;
    out_ready = 1'b0;
    @(negedge clock);
    in_state = a; in_mode = 2'b00; in_valid = 1'b1;
    @(posedge clock); #1;
    in_state = b;
    seen = 3'b000;
    for (int cyc = 0; cyc < 20 && seen != 3'b111; cyc++) begin
      @(posedge clock); #1;
      seen = out_valid;
    end
    chk("stall_all_valid", {125'd0, seen}, 128'd7);
    for (int i = 0; i < 3; i++) snap[i] = out_state[i];
    stable = 3'b111;
    repeat (20) begin
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++)
        if (out_state[i] !== snap[i] || in_ready[i] !== 1'b0 || out_valid[i] !== 1'b1)
          stable[i] = 1'b0;
    end
    chk("stall_stable", {125'd0, stable}, 128'd7);
    for (int i = 0; i < 3; i++) chk($sformatf("stall_state_u%0d", i), snap[i], ref_mix(a, 2'b00));
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("stall_no_second_valid", {125'd0, out_valid}, 128'd0);
    chk("stall_no_second_busy", {125'd0, busy}, 128'd0);
    chk("stall_ready_again", {125'd0, in_ready}, 128'd7);

    // Reset during the first RUN cycle of the one-column engine.
    @(negedge clock);
    in_state = v2; in_mode = 2'b00; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_in_ready", {125'd0, in_ready}, 128'd7);
    chk("midrst_out_valid", {125'd0, out_valid}, 128'd0);
    chk("midrst_busy", {125'd0, busy}, 128'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("midrst_out_state_u%0d", i), out_state[i], '0);
    @(negedge clock);
    reset = 1'b0;
    seen = 3'b000;
    repeat (8) begin
      @(posedge clock); #1;
      seen |= out_valid;
    end
    chk("midrst_no_partial", {125'd0, seen}, 128'd0);

    run(v1, 2'b00); check_txn("post_reset_fwd", e1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
